// File: rtl/mac_frame_tx.sv
// Ethernet MAC transmit framer: preamble/SFD, addresses, EtherType, payload with
// zero padding to the 46-byte minimum, CRC-32 FCS and inter-frame gap onto GMII.
module mac_frame_tx #(
    parameter logic [47:0] P_SRC_MAC = 48'h000000000000,
    parameter int unsigned P_IFG     = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_src_mac,
    input  logic        i_src_mac_valid,
    input  logic [47:0] i_dest_mac,
    input  logic [15:0] i_send_type,
    input  logic        i_send_req,
    input  logic [7:0]  i_send_data,
    input  logic        i_send_valid,
    input  logic        i_send_last,
    output logic        o_send_ready,
    output logic        o_busy,
    output logic        o_underrun,
    output logic [7:0]  o_gmii_data,
    output logic        o_gmii_valid
);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StStart   = 4'd1;
    localparam logic [3:0] StPre     = 4'd2;
    localparam logic [3:0] StSfd     = 4'd3;
    localparam logic [3:0] StDmac    = 4'd4;
    localparam logic [3:0] StSmac    = 4'd5;
    localparam logic [3:0] StType    = 4'd6;
    localparam logic [3:0] StPayload = 4'd7;
    localparam logic [3:0] StPad     = 4'd8;
    localparam logic [3:0] StFcs     = 4'd9;
    localparam logic [3:0] StIfg     = 4'd10;

    localparam logic [15:0] MinPayload = 16'd46;
    localparam logic [15:0] MaxPayload = 16'd1500;
    // GMII output is registered, so the START cycle supplies the last idle cycle of the gap.
    localparam int unsigned IfgCycles  = (P_IFG > 1) ? P_IFG - 1 : 1;
    localparam logic [15:0] IfgLast    = 16'(IfgCycles - 1);

    logic [3:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [47:0] dmac_q, dmac_d;
    logic [47:0] smac_q, smac_d;
    logic [15:0] type_q, type_d;
    logic [47:0] src_mac_q;
    logic        bad_q, bad_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        underrun_q, underrun_d;
    logic        crc_en;
    logic        start;
    logic [15:0] pay_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pay_cnt_d  = pay_cnt_q;
        crc_d      = crc_q;
        dmac_d     = dmac_q;
        smac_d     = smac_q;
        type_d     = type_q;
        bad_d      = bad_q;
        data_d     = 8'h00;
        valid_d    = 1'b0;
        underrun_d = 1'b0;
        crc_en     = 1'b0;
        start      = 1'b0;
        pay_next   = pay_cnt_q + 16'd1;

        case (state_q)
            StIdle: start = i_send_req;
            StStart: begin
                state_d = StPre;
                cnt_d   = 16'd0;
            end
            StPre: begin
                valid_d = 1'b1;
                data_d  = 8'h55;
                if (cnt_q == 16'd6) begin
                    state_d = StSfd;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSfd: begin
                valid_d = 1'b1;
                data_d  = 8'hD5;
                state_d = StDmac;
                cnt_d   = 16'd0;
            end
            StDmac: begin
                valid_d = 1'b1;
                data_d  = dmac_q[47:40];
                dmac_d  = {dmac_q[39:0], 8'h00};
                crc_en  = 1'b1;
                if (cnt_q == 16'd5) begin
                    state_d = StSmac;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSmac: begin
                valid_d = 1'b1;
                data_d  = smac_q[47:40];
                smac_d  = {smac_q[39:0], 8'h00};
                crc_en  = 1'b1;
                if (cnt_q == 16'd5) begin
                    state_d = StType;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StType: begin
                valid_d = 1'b1;
                data_d  = type_q[15:8];
                type_d  = {type_q[7:0], 8'h00};
                crc_en  = 1'b1;
                if (cnt_q == 16'd1) begin
                    state_d   = StPayload;
                    pay_cnt_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StPayload: begin
                valid_d   = 1'b1;
                crc_en    = 1'b1;
                pay_cnt_d = pay_next;
                cnt_d     = 16'd0;
                if (i_send_valid) begin
                    data_d = i_send_data;
                    if (i_send_last) begin
                        state_d = (pay_next < MinPayload) ? StPad : StFcs;
                    end else if (pay_next == MaxPayload) begin
                        underrun_d = 1'b1;
                        bad_d      = 1'b1;
                        state_d    = StFcs;
                    end
                end else begin
                    // Starved: this cycle already goes out as the first pad byte.
                    underrun_d = 1'b1;
                    bad_d      = 1'b1;
                    state_d    = (pay_next < MinPayload) ? StPad : StFcs;
                end
            end
            StPad: begin
                valid_d   = 1'b1;
                crc_en    = 1'b1;
                pay_cnt_d = pay_next;
                if (pay_next >= MinPayload) begin
                    state_d = StFcs;
                    cnt_d   = 16'd0;
                end
            end
            StFcs: begin
                valid_d = 1'b1;
                data_d  = bad_q ? crc_q[7:0] : ~crc_q[7:0];
                crc_d   = {8'h00, crc_q[31:8]};
                if (cnt_q == 16'd3) begin
                    state_d = StIfg;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StIfg: begin
                if (cnt_q == IfgLast) begin
                    state_d = StIdle;
                    start   = i_send_req;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (crc_en) begin
            crc_d = crc_byte(crc_q, data_d);
        end

        if (start) begin
            state_d = StStart;
            cnt_d   = 16'd0;
            dmac_d  = i_dest_mac;
            type_d  = i_send_type;
            smac_d  = src_mac_q;
            crc_d   = 32'hFFFFFFFF;
            bad_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            pay_cnt_q  <= 16'd0;
            crc_q      <= 32'hFFFFFFFF;
            dmac_q     <= 48'h0;
            smac_q     <= 48'h0;
            type_q     <= 16'h0;
            bad_q      <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            crc_q      <= crc_d;
            dmac_q     <= dmac_d;
            smac_q     <= smac_d;
            type_q     <= type_d;
            bad_q      <= bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_mac_q <= P_SRC_MAC;
        end else if (i_src_mac_valid) begin
            src_mac_q <= i_src_mac;
        end
    end

    assign o_send_ready = (state_q == StPayload);
    assign o_busy       = (state_q != StIdle);
    assign o_underrun   = underrun_q;
    assign o_gmii_data  = data_q;
    assign o_gmii_valid = valid_q;

endmodule

// File: doc/mac_frame_tx.md
MAC_FRAME_TX -- requirements
Module: mac_frame_tx

Interface
REQ-001 SHALL have parameter P_SRC_MAC, default 48'h000000000000, local MAC used as source address after reset.
REQ-002 SHALL have parameter P_IFG, default 12, number of idle cycles enforced after each frame's last FCS byte.
REQ-003 SHALL have ports i_clk input 1 (clock) and i_rst input 1; reset i_rst is asynchronous, active-high; clock i_clk.
REQ-004 SHALL have ports i_src_mac input 48 and i_src_mac_valid input 1, a runtime override of the source MAC.
REQ-005 SHALL have ports i_dest_mac input 48 and i_send_type input 16, the destination MAC and EtherType, both sampled at frame start.
REQ-006 SHALL have port i_send_req input 1, a level request to start a frame.
REQ-007 SHALL have ports i_send_data input 8, i_send_valid input 1 and i_send_last input 1, the payload byte stream.
REQ-008 SHALL have port o_send_ready output 1, meaning the block samples a payload byte this cycle.
REQ-009 SHALL have ports o_busy output 1 (a frame or IFG is in progress) and o_underrun output 1 (one-cycle error pulse).
REQ-010 SHALL have ports o_gmii_data output 8 and o_gmii_valid output 1, the GMII transmit bytes and TX_EN.

Function
REQ-011 SHALL load the source MAC register from i_src_mac when i_src_mac_valid=1, and SHALL use the new value only from the next frame start.
REQ-012 SHALL implement the FSM IDLE->PRE(7 bytes 0x55)->SFD(0xD5)->DMAC(6)->SMAC(6)->TYPE(2)->PAYLOAD->PAD->FCS(4)->IFG(P_IFG)->IDLE.
REQ-013 In IDLE with i_send_req=1 the FSM SHALL latch i_dest_mac, i_send_type and the source MAC, and o_gmii_valid SHALL rise on the second rising edge after that sample.
REQ-014 SHALL send the MAC addresses and the type MSB byte first (byte [47:40] first; type [15:8] first).
REQ-015 o_send_ready SHALL be high in the cycle o_gmii_data carries the second type byte, and in every subsequent PAYLOAD cycle up to and including the cycle the i_send_last byte is accepted.
REQ-016 A byte sampled while o_send_ready=1 and i_send_valid=1 SHALL appear on o_gmii_data on the next cycle, with no bubbles.
REQ-017 If i_send_valid=0 while o_send_ready=1 (underrun), the block SHALL pulse o_underrun for one cycle, drop ready, send the remaining bytes as PAD, and transmit the complemented correct FCS (bitwise inverse) so the frame is detectably bad.
REQ-018 A 16-bit payload counter SHALL count accepted bytes; on reaching 1500 without i_send_last, the block SHALL drop ready, pulse o_underrun, and go to FCS with the inverted FCS.
REQ-019 If the payload count is <46 at the end of the payload, the block SHALL send 0x00 pad bytes until the payload+pad total is 46; otherwise the PAD state SHALL be skipped.
REQ-020 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) SHALL cover DMAC through the last pad byte and exclude the preamble and SFD.
REQ-021 The transmitted FCS SHALL be ~crc, sent low byte first (crc[7:0] first).
REQ-022 o_gmii_valid SHALL be 1 from the first preamble byte through the last FCS byte, contiguously, and 0 otherwise.
REQ-023 o_gmii_data SHALL be 0x00 whenever o_gmii_valid=0.
REQ-024 o_busy SHALL be 1 from the request sample through the end of IFG.
REQ-025 i_send_req SHALL be ignored outside IDLE; a request held through IFG SHALL start the next frame immediately after IFG.
REQ-026 i_send_valid and i_send_last SHALL be ignored while o_send_ready=0.

Reset
REQ-027 On i_rst assertion, at any time including mid-frame, all outputs SHALL go to 0 immediately, the FSM SHALL go to IDLE, the CRC SHALL be set to 0xFFFFFFFF, and the source MAC SHALL be set to P_SRC_MAC.
REQ-028 After reset release, the first frame SHALL start only on a fresh i_send_req sample, with no IFG required.

Verification
REQ-029 A 46-byte payload with type 0x0806 and dest FF:FF:FF:FF:FF:FF -> 72 contiguous valid bytes (8+6+6+2+46+4), no pad, FCS equal to the golden CRC model.
REQ-030 A 10-byte payload (0x01..0x0A) -> 36 bytes of 0x00 pad, 72 valid bytes total, FCS computed over the pad included.
REQ-031 A 100-byte IP frame (type 0x0800) looped into the team's MAC receiver -> 126 valid bytes; receiver crc_error=0; received type 0x0800 and source MAC match.
REQ-032 Two back-to-back requests with i_send_req held -> exactly P_IFG=12 cycles with o_gmii_valid=0 between frames.
REQ-033 i_send_valid dropped after 20 payload bytes -> one o_underrun pulse, 26 pad bytes, FCS equal to the inverse of golden, receiver crc_error=1.
REQ-034 i_rst pulsed during the SMAC state -> o_gmii_valid=0 and o_busy=0 immediately; a following request produces a correct frame with the preamble first.
